tick_scheduler: RTL and testbench

//   Multi-channel tick generator sharing one clock prescaler. Each channel owns a runtime-programmable

---
 rtl/tick_scheduler_if.sv | 30 +++
 rtl/tick_scheduler.sv | 109 ++++++++++
 tb/tb_tick_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/tick_scheduler_if.sv
// rtl/tick_scheduler_if.sv - config request/response bundle for tick_scheduler
interface tick_scheduler_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 26
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_enable;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_period,
        output cfg_enable,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_period,
        input  cfg_enable,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - multi-channel tick/square-wave generator on a shared prescaler
module tick_scheduler #(
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2,
    parameter int CNT_W    = 26,
    parameter int PRESCALE = 50
) (
    input  logic                clk,
    input  logic                rst,
    tick_scheduler_if.slave     cfg,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] active
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] pcnt;
    logic            base;

    logic [CNT_W-1:0]    period      [CHANNELS];
    logic [CNT_W-1:0]    cnt         [CHANNELS];
    logic [CNT_W-1:0]    pend_period [CHANNELS];
    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] pend_en;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] ch_hit;
    logic                in_range;
    logic                cfg_fire;

    // base is registered so it is a clean one-cycle pulse once per prescaler wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            base <= 1'b0;
        end else begin
            base <= (pcnt == PS_LAST);
            pcnt <= (pcnt == PS_LAST) ? '0 : pcnt + PS_W'(1);
        end
    end

    always_comb begin
        ch_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ch_hit[i] = (cfg.cfg_ch == CH_W'(i));
        end
    end

    // out-of-range indices hit no channel, so they are always ready
    assign in_range      = |ch_hit;
    assign cfg.cfg_ready = !(|(ch_hit & pend));
    assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
    assign active        = en;

    always_comb begin
        wrap = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i] = base && en[i] && (cnt[i] == period[i] - CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick        <= '0;
            level       <= '0;
            en          <= '0;
            pend        <= '0;
            pend_en     <= '0;
            cfg.cfg_err <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                period[i]      <= '0;
                cnt[i]         <= '0;
                pend_period[i] <= '0;
            end
        end else begin
            cfg.cfg_err <= cfg_fire && !in_range;
            for (int i = 0; i < CHANNELS; i++) begin
                tick[i] <= wrap[i];
                if (base && en[i]) begin
                    cnt[i] <= wrap[i] ? '0 : cnt[i] + CNT_W'(1);
                end
                if (wrap[i]) begin
                    level[i] <= ~level[i];
                end
                // pending update lands immediately when idle, otherwise only on a wrap
                if (pend[i] && (!en[i] || wrap[i])) begin
                    pend[i] <= 1'b0;
                    cnt[i]  <= '0;
                    if (pend_en[i] && (pend_period[i] != '0)) begin
                        en[i]     <= 1'b1;
                        period[i] <= pend_period[i];
                    end else begin
                        en[i]    <= 1'b0;
                        level[i] <= 1'b0;
                    end
                end
                // pend was clear here, so this never collides with the apply above
                if (cfg_fire && ch_hit[i]) begin
                    pend[i]        <= 1'b1;
                    pend_period[i] <= cfg.cfg_period;
                    pend_en[i]     <= cfg.cfg_enable;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - randomized bench for tick_scheduler against an edge-schedule model
module tb_tick_scheduler;

    localparam int CHANNELS = 4;
    localparam int CH_W     = 3;
    localparam int CNT_W    = 26;
    localparam int PRESCALE = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] active;

    tick_scheduler_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_bus ();

    tick_scheduler #(
        .CHANNELS(CHANNELS), .CH_W(CH_W), .CNT_W(CNT_W), .PRESCALE(PRESCALE)
    ) dut (
        .clk(clk), .rst(rst), .cfg(cfg_bus), .tick(tick), .level(level), .active(active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model: each enabled channel holds the absolute edge number of its next wrap.
    // Edge 1 is the first edge after reset; base-driven steps happen on edges 1+m*PRESCALE, m>=1.
    longint edge_n;
    bit     m_en   [CHANNELS];
    int     m_per  [CHANNELS];
    longint m_next [CHANNELS];
    bit     m_lvl  [CHANNELS];
    bit     m_tick [CHANNELS];
    bit     m_pend [CHANNELS];
    int     m_pper [CHANNELS];
    bit     m_pen  [CHANNELS];
    bit     m_err;

    function automatic longint first_base_after(input longint e);
        return 1 + PRESCALE * ((e - 1) / PRESCALE + 1);
    endfunction

    task automatic model_reset();
        edge_n = 0;
        m_err  = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            m_en[i] = 0; m_per[i] = 0; m_next[i] = 0; m_lvl[i] = 0;
            m_tick[i] = 0; m_pend[i] = 0; m_pper[i] = 0; m_pen[i] = 0;
        end
    endtask

    task automatic model_step(input bit r, input bit v, input int ch, input int per,
                              input bit e, input bit rdy);
        if (r) begin
            model_reset();
            return;
        end
        edge_n++;
        for (int i = 0; i < CHANNELS; i++) begin
            bit w;
            w = m_en[i] && (edge_n == m_next[i]);
            m_tick[i] = w;
            if (w) begin
                m_lvl[i]  = !m_lvl[i];
                m_next[i] = edge_n + PRESCALE * m_per[i];
            end
            if (m_pend[i] && (!m_en[i] || w)) begin
                m_pend[i] = 0;
                if (m_pen[i] && m_pper[i] != 0) begin
                    if (!m_en[i]) m_next[i] = first_base_after(edge_n) + (m_pper[i] - 1) * PRESCALE;
                    else          m_next[i] = edge_n + PRESCALE * m_pper[i];
                    m_en[i]  = 1;
                    m_per[i] = m_pper[i];
                end else begin
                    m_en[i]  = 0;
                    m_lvl[i] = 0;
                end
            end
        end
        m_err = v && rdy && (ch >= CHANNELS);
        if (v && rdy && ch < CHANNELS) begin
            m_pend[ch] = 1;
            m_pper[ch] = per;
            m_pen[ch]  = e;
        end
    endtask

    task automatic cycle(input bit r, input bit v, input int ch, input int per, input bit e,
                         output bit acc);
        logic [CHANNELS-1:0] et, el, ea;
        bit exp_rdy;
        @(negedge clk);
        for (int i = 0; i < CHANNELS; i++) begin
            et[i] = m_tick[i]; el[i] = m_lvl[i]; ea[i] = m_en[i];
        end
        check_eq("tick", 32'(tick), 32'(et));
        check_eq("level", 32'(level), 32'(el));
        check_eq("active", 32'(active), 32'(ea));
        check_eq("cfg_err", 32'(cfg_bus.cfg_err), 32'(m_err));
        rst                = r;
        cfg_bus.cfg_valid  = v;
        cfg_bus.cfg_ch     = ch[CH_W-1:0];
        cfg_bus.cfg_period = per[CNT_W-1:0];
        cfg_bus.cfg_enable = e;
        #1;
        exp_rdy = (ch >= CHANNELS) ? 1'b1 : !m_pend[ch];
        check_eq("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(exp_rdy));
        acc = v && exp_rdy && !r;
        model_step(r, v, ch, per, e, exp_rdy);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, acc);
    endtask

    task automatic send(input int ch, input int per, input bit e);
        bit acc = 0;
        for (int k = 0; k < 200 && !acc; k++) cycle(0, 1, ch, per, e, acc);
        check_eq("send_accepted", 32'(acc), 32'd1);
    endtask

    initial begin
        bit acc;
        int t_prev;
        int seen;
        rst                = 1'b1;
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_ch     = '0;
        cfg_bus.cfg_period = '0;
        cfg_bus.cfg_enable = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, acc);

        // ch0 period 3: ticks 12 clk apart
        send(0, 3, 1);
        t_prev = -1;
        seen   = 0;
        for (int k = 0; k < 60; k++) begin
            cycle(0, 0, 0, 0, 0, acc);
            if (tick[0]) begin
                if (t_prev >= 0) check_eq("t1_spacing", 32'(k - t_prev), 32'd12);
                t_prev = k;
                seen++;
            end
        end
        check_eq("t1_ticks_seen", 32'(seen >= 4), 32'd1);

        // mid-period change, back-to-back stall, out-of-range, disable and period=0
        idle(5);
        send(0, 5, 1);
        idle(50);
        send(1, 2, 1);
        idle(10);
        send(1, 4, 1);
        send(1, 3, 1);
        idle(40);
        send(5, 3, 1);
        idle(3);
        send(2, 3, 1);
        idle(20);
        send(2, 3, 0);
        send(3, 0, 1);
        idle(40);

        // reset with an update still pending on ch0
        send(0, 2, 1);
        cycle(1, 1, 1, 2, 1, acc);
        idle(30);

        for (int k = 0; k < 3000; k++) begin
            bit r, v, e;
            int ch, per;
            r   = ($urandom_range(0, 399) == 0);
            v   = ($urandom_range(0, 9) < 4);
            ch  = $urandom_range(0, 5);
            per = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            e   = ($urandom_range(0, 5) != 0);
            cycle(r, v, ch, per, e, acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
